// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two requesters share one synchronous-read memory port, round-robin with bounded bursts.
// Latency: gnt is combinational; the memory sees the access 1 cycle after grant; rvalid/rdata arrive 2 cycles after grant.
// Backpressure: requesters hold req until gnt; an owner keeps the port for at most HOLD_MAX grants while the other waits.
// Optional feature macro: ARB_STATS_EN builds the per-requester starvation counters wait_cnt0/wait_cnt1.
module mem_port_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       wait_cnt0,
  output logic [15:0]       wait_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  // Hold counter value at which a waiting requester takes the port over.
  localparam logic [3:0] CNT_TOP = 4'(HOLD_MAX - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              last;

  logic              sel_vld;
  logic              sel;
  logic              own_match;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Read-return tracking: stage 1 covers the memory access cycle, stage 2 the data cycle.
  logic              s1_vld;
  logic              s1_id;
  logic              s2_vld;
  logic              s2_id;

  // Pick at most one requester this cycle from the current owner, hold count and request levels.
  always_comb begin
    sel_vld = 1'b0;
    sel     = 1'b0;
    case (state)
      OWN0: begin
        if (req0) begin
          sel_vld = 1'b1;
          sel     = req1 && (cnt == CNT_TOP);
        end else if (req1) begin
          sel_vld = 1'b1;
          sel     = 1'b1;
        end
      end
      OWN1: begin
        if (req1) begin
          sel_vld = 1'b1;
          sel     = !(req0 && (cnt == CNT_TOP));
        end else if (req0) begin
          sel_vld = 1'b1;
          sel     = 1'b0;
        end
      end
      default: begin
        if (req0 && req1) begin
          sel_vld = 1'b1;
          sel     = !last;
        end else if (req0) begin
          sel_vld = 1'b1;
          sel     = 1'b0;
        end else if (req1) begin
          sel_vld = 1'b1;
          sel     = 1'b1;
        end
      end
    endcase
  end

  // Grants are suppressed while reset is held so nothing is accepted that would be lost.
  assign gnt0 = sel_vld && !sel && !reset;
  assign gnt1 = sel_vld &&  sel && !reset;

  // The selected requester keeps its run going only if it already owned the port.
  assign own_match = ((state == OWN0) && !sel) || ((state == OWN1) && sel);

  // Request fields of the selected requester, steered onto the memory registers.
  assign sel_we    = sel ? we1    : we0;
  assign sel_addr  = sel ? addr1  : addr0;
  assign sel_wdata = sel ? wdata1 : wdata0;

  // Ownership FSM: owner, burst length and last-served requester for round-robin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      last  <= 1'b1;
    end else if (sel_vld) begin
      state <= sel ? OWN1 : OWN0;
      last  <= sel;
      if (own_match) begin
        cnt <= (cnt >= CNT_TOP) ? CNT_TOP : cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
    end else begin
      state <= IDLE;
      cnt   <= 4'd0;
    end
  end

  // Memory port registers: load on grant; strobe drops on idle cycles, address/data hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
    end else if (sel_vld) begin
      mem_addr <= sel_addr;
      mem_din  <= sel_wdata;
      mem_we   <= sel_we;
    end else begin
      mem_we   <= 1'b0;
    end
  end

  // Two-stage read tag pipeline matching the one-cycle register plus one-cycle memory read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_id  <= 1'b0;
      s2_vld <= 1'b0;
      s2_id  <= 1'b0;
    end else begin
      s1_vld <= sel_vld && !sel_we;
      s1_id  <= sel;
      s2_vld <= s1_vld;
      s2_id  <= s1_id;
    end
  end

  assign rvalid0 = s2_vld && !s2_id;
  assign rvalid1 = s2_vld &&  s2_id;
  assign rdata   = mem_dout;

`ifdef ARB_STATS_EN
  // Starvation counters: count cycles a request waits without a grant, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt0 <= 16'd0;
      wait_cnt1 <= 16'd0;
    end else begin
      if (req0 && !gnt0 && (wait_cnt0 != 16'hFFFF)) begin
        wait_cnt0 <= wait_cnt0 + 16'd1;
      end
      if (req1 && !gnt1 && (wait_cnt1 != 16'hFFFF)) begin
        wait_cnt1 <= wait_cnt1 + 16'd1;
      end
    end
  end
`else
  assign wait_cnt0 = 16'd0;
  assign wait_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: grant-sequence table, directed multi-cycle corner cases,
// then random traffic checked against a request-level reference model with a shadow memory.
module tb_mem_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int HM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic [15:0]   wait_cnt0, wait_cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .wait_cnt0(wait_cnt0), .wait_cnt1(wait_cnt1)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory behind the port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- reference model (request level) ----------------
  typedef struct {
    int            due;
    int            id;
    logic [15:0]   data;
  } rd_t;

  rd_t         exp_q[$];
  logic [15:0] sh [int];
  int          m_owner;
  int          m_run;
  int          m_last;
  int          mwait0, mwait1;

  function automatic logic [15:0] rd_shadow(input int a);
    if (sh.exists(a)) return sh[a];
    return init_val(a);
  endfunction

  // Round-robin with a burst limit: the owner may take HM grants in a row while the other waits.
  function automatic int pick(input logic r0, input logic r1);
    logic [1:0] r;
    r = {r1, r0};
    if (m_owner < 0) begin
      if (r0 && r1) return (m_last == 0) ? 1 : 0;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    if (r[m_owner]) begin
      if (r[1 - m_owner] && m_run >= HM) return 1 - m_owner;
      return m_owner;
    end
    if (r[1 - m_owner]) return 1 - m_owner;
    return -1;
  endfunction

  task automatic chk_rd();
    logic e0, e1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (exp_q[0].id == 0) e0 = 1'b1;
      else e1 = 1'b1;
    end
    chk("r_rvalid0", rvalid0, e0);
    chk("r_rvalid1", rvalid1, e1);
    if (e0 || e1) begin
      chk("r_rdata", rdata, exp_q[0].data);
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- grant table ----------------
  typedef struct {
    logic r0;
    logic r1;
    logic g0;
    logic g1;
  } vec_t;

  vec_t tbl[22];

  initial begin
    int   wec;
    int   eg;
    logic dg0, dg1;
    logic w;
    int   a;
    logic [15:0] d;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'h0BAD;

    // Reset state, with both requests high to show grants stay off.
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b1;
    addr0 = 15'h0001; addr1 = 15'h0002; wdata0 = 16'h1111; wdata1 = 16'h2222;
    smp();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wait_cnt0", wait_cnt0, 0);
    chk("rst_wait_cnt1", wait_cnt1, 0);
    do_reset();

    // Single read of 0x0010.
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
    smp();
    chk("a_gnt0", gnt0, 1);
    chk("a_gnt1", gnt1, 0);
    next(); req0 = 1'b0;
    smp();
    chk("a_rvalid0_c1", rvalid0, 0);
    chk("a_mem_addr", mem_addr, 15'h0010);
    chk("a_mem_we", mem_we, 0);
    next(); smp();
    chk("a_rvalid0_c2", rvalid0, 1);
    chk("a_rvalid1_c2", rvalid1, 0);
    chk("a_rdata", rdata, 16'hBEEF);
    next(); smp();
    chk("a_rvalid0_c3", rvalid0, 0);
    next();

    // Write then read of 0x7FFF from requester 1 on consecutive grants.
    wec = 0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h7FFF; wdata1 = 16'h1234;
    smp();
    chk("b_gnt1_wr", gnt1, 1);
    wec += int'(mem_we);
    next(); we1 = 1'b0;
    smp();
    chk("b_gnt1_rd", gnt1, 1);
    chk("b_mem_we", mem_we, 1);
    chk("b_mem_addr", mem_addr, 15'h7FFF);
    chk("b_mem_din", mem_din, 16'h1234);
    wec += int'(mem_we);
    next(); req1 = 1'b0;
    smp();
    chk("b_rvalid1_c1", rvalid1, 0);
    wec += int'(mem_we);
    next(); smp();
    chk("b_rvalid1", rvalid1, 1);
    chk("b_rvalid0", rvalid0, 0);
    chk("b_rdata", rdata, 16'h1234);
    wec += int'(mem_we);
    next(); smp();
    wec += int'(mem_we);
    chk("b_we_cycles", wec, 1);
    next();

    // Reset in the cycle after a read grant: read is discarded.
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010;
    smp();
    chk("c_gnt0", gnt0, 1);
    next();
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0010;
    smp();
    chk("c_rst_gnt0", gnt0, 0);
    chk("c_rst_gnt1", gnt1, 0);
    chk("c_rst_mem_we", mem_we, 0);
    chk("c_rst_rvalid0", rvalid0, 0);
    next(); smp();
    chk("c_rst_rvalid0_c2", rvalid0, 0);
    chk("c_rst_rvalid1_c2", rvalid1, 0);
    next(); reset = 1'b0;
    smp();
    chk("c_post_gnt0", gnt0, 1);
    chk("c_post_gnt1", gnt1, 0);
    next(); req0 = 1'b0; req1 = 1'b0;
    next(); next(); next();

    // Reset in the cycle after a write grant: the write never commits.
    req1 = 1'b1; we1 = 1'b1; addr1 = 15'h0020; wdata1 = 16'hDEAD;
    smp();
    chk("c_wr_gnt1", gnt1, 1);
    next();
    reset = 1'b1; req1 = 1'b0; we1 = 1'b0;
    smp();
    chk("c_wr_mem_we", mem_we, 0);
    next(); reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0020;
    smp();
    chk("c_rd_gnt0", gnt0, 1);
    next(); req0 = 1'b0;
    smp(); next(); smp();
    chk("c_rd_rvalid0", rvalid0, 1);
    chk("c_rd_rdata", rdata, 16'h0BAD);
    next();

    // Grant sequence table from a clean reset (reads only).
    do_reset();
    we0 = 1'b0; we1 = 1'b0; addr0 = 15'h0000; addr1 = 15'h0001;
    for (int i = 0; i < 22; i++) begin
      req0 = tbl[i].r0;
      req1 = tbl[i].r1;
      smp();
      chk($sformatf("tbl%0d_gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("tbl%0d_gnt1", i), gnt1, tbl[i].g1);
      next();
    end

    // Starvation statistics: requester 1 blocked for 4 cycles.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk($sformatf("d_gnt0_%0d", i), gnt0, 1);
      next();
    end
    req0 = 1'b0;
    smp();
    chk("d_gnt1", gnt1, 1);
    next(); req1 = 1'b0;
    smp();
`ifdef ARB_STATS_EN
    chk("d_wait_cnt1", wait_cnt1, 4);
`else
    chk("d_wait_cnt1", wait_cnt1, 0);
`endif
    chk("d_wait_cnt0", wait_cnt0, 0);
    next();

    // Random traffic against the reference model.
    do_reset();
    m_owner = -1; m_run = 0; m_last = 1;
    mwait0 = 0; mwait1 = 0; cyc = 0;
    exp_q.delete();
    dg0 = 1'b0; dg1 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!req0 || dg0) begin
        if ($urandom_range(0, 99) < 60) begin
          req0 = 1'b1;
          we0 = ($urandom_range(0, 2) == 0);
          addr0 = 15'h0100 + 15'($urandom_range(0, 15));
          wdata0 = 16'($urandom);
        end else req0 = 1'b0;
      end
      if (!req1 || dg1) begin
        if ($urandom_range(0, 99) < 60) begin
          req1 = 1'b1;
          we1 = ($urandom_range(0, 2) == 0);
          addr1 = 15'h0100 + 15'($urandom_range(0, 15));
          wdata1 = 16'($urandom);
        end else req1 = 1'b0;
      end
      smp();
      eg = pick(req0, req1);
      chk("r_gnt0", gnt0, (eg == 0));
      chk("r_gnt1", gnt1, (eg == 1));
      chk_rd();
      dg0 = gnt0;
      dg1 = gnt1;
      if (req0 && eg != 0) mwait0++;
      if (req1 && eg != 1) mwait1++;
      if (eg >= 0) begin
        if (eg == m_owner) m_run++;
        else m_run = 1;
        m_owner = eg;
        m_last = eg;
        w = (eg == 1) ? we1 : we0;
        a = (eg == 1) ? int'(addr1) : int'(addr0);
        d = (eg == 1) ? wdata1 : wdata0;
        if (w) sh[a] = d;
        else exp_q.push_back('{cyc + 2, eg, rd_shadow(a)});
      end else begin
        m_owner = -1;
        m_run = 0;
      end
      cyc++;
      next();
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk_rd();
      cyc++;
      next();
    end
    smp();
`ifdef ARB_STATS_EN
    chk("r_wait_cnt0", wait_cnt0, (mwait0 > 65535) ? 65535 : mwait0);
    chk("r_wait_cnt1", wait_cnt1, (mwait1 > 65535) ? 65535 : mwait1);
`else
    chk("r_wait_cnt0", wait_cnt0, 0);
    chk("r_wait_cnt1", wait_cnt1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
